// File: rtl/usb_hid_pkg.sv
// Shared encodings and types for the HID report decoder and its event FIFO.
package usb_hid_pkg;

  localparam logic [1:0] TYP_NONE  = 2'd0;
  localparam logic [1:0] TYP_KBD   = 2'd1;
  localparam logic [1:0] TYP_MOUSE = 2'd2;
  localparam logic [1:0] TYP_GAME  = 2'd3;

  localparam logic [7:0] HID_ERR_ROLLOVER = 8'h01;
  localparam logic [7:0] HID_MOD_BASE     = 8'hE0;

  localparam int unsigned EVT_W = 9;

  typedef struct packed {
    logic       press;
    logic [7:0] usage;
  } hid_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_BRK,
    ST_MK,
    ST_MOD,
    ST_COMMIT
  } kbd_state_e;

endpackage

// File: rtl/hid_evt_fifo.sv
// Key event FIFO; pointers carry an extra wrap bit to tell full from empty.
module hid_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_c, do_pop_c;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_c  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_c = push_i & (~full_o | do_pop_c);
  assign data_o    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push_c) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop_c)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (do_push_c) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/usb_hid_report_decoder.sv
// Captures a ukp report frame and decodes it as keyboard (state diff + events),
// mouse (saturating accumulators) or gamepad (raw latch) according to typ.
module usb_hid_report_decoder
  import usb_hid_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned NUM_KEYS  = 6,
  parameter int unsigned EVT_DEPTH = 8,
  parameter int unsigned ACC_W     = 12
) (
  input  logic                    usbclk,
  input  logic                    usbrst_n,
  input  logic [1:0]              typ,
  input  logic                    rpt_rdy,
  input  logic                    rpt_stb,
  input  logic [7:0]              rpt_dat,
  output logic                    report,
  output logic                    frame_err,
  output logic [7:0]              key_modifiers,
  output logic [8*NUM_KEYS-1:0]   keys,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [EVT_W-1:0]        evt_data,
  output logic                    evt_ovf,
  output logic [7:0]              mouse_btn,
  output logic [ACC_W-1:0]        mouse_dx,
  output logic [ACC_W-1:0]        mouse_dy,
  output logic [ACC_W-1:0]        mouse_wh,
  input  logic                    mouse_clr,
  output logic [8*MAX_BYTES-1:0]  game_raw
);

  localparam int unsigned CNT_W   = $clog2(MAX_BYTES + 1);
  localparam int unsigned IDX_MAX = (NUM_KEYS > 8) ? NUM_KEYS : 8;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX);
  localparam int unsigned SLOT_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic                           rdy_q, rdy_d, stb_q, stb_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [MAX_BYTES-1:0][7:0]      rbuf_q, rbuf_d, byte_c;
  kbd_state_e                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [SLOT_W-1:0]              slot_c;
  logic [7:0]                     new_mod_q, new_mod_d, old_mod_q, old_mod_d;
  logic [NUM_KEYS-1:0][7:0]       new_keys_q, new_keys_d, old_keys_q, old_keys_d;
  logic [NUM_KEYS-1:0][7:0]       keys_q, keys_d;
  logic [7:0]                     mods_q, mods_d, btn_q, btn_d;
  logic                           report_q, report_d, ferr_q, ferr_d;
  logic                           evt_ovf_q, evt_ovf_d;
  logic [ACC_W-1:0]               dx_q, dx_d, dy_q, dy_d, wh_q, wh_d;
  logic [MAX_BYTES-1:0][7:0]      game_q, game_d;
  logic                           push_c, drop_c, hit_c, dup_c;
  hid_evt_t                       push_evt_c;
  logic                           evt_empty_c, evt_full_c;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [7:0]       d);
    logic [ACC_W:0] s;
    s = {acc[ACC_W-1], acc} + {{(ACC_W-7){d[7]}}, d};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // Bytes at or beyond the captured count read as zero.
  always_comb begin
    for (int i = 0; i < int'(MAX_BYTES); i++)
      byte_c[i] = (CNT_W'(i) < cnt_q) ? rbuf_q[i] : 8'h00;
  end

  assign slot_c = idx_q[SLOT_W-1:0];

  always_comb begin
    rdy_d      = rpt_rdy;
    stb_d      = rpt_stb;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    state_d    = state_q;
    idx_d      = idx_q;
    new_mod_d  = new_mod_q;
    new_keys_d = new_keys_q;
    old_mod_d  = old_mod_q;
    old_keys_d = old_keys_q;
    keys_d     = keys_q;
    mods_d     = mods_q;
    report_d   = 1'b0;
    ferr_d     = 1'b0;
    btn_d      = btn_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    wh_d       = wh_q;
    game_d     = game_q;
    push_c     = 1'b0;
    push_evt_c = '0;
    hit_c      = 1'b0;
    dup_c      = 1'b0;

    if (!rpt_rdy) begin
      cnt_d = '0;
    end else if (rpt_stb && !stb_q && cnt_q != CNT_W'(MAX_BYTES)) begin
      for (int i = 0; i < int'(MAX_BYTES); i++)
        if (cnt_q == CNT_W'(i)) rbuf_d[i] = rpt_dat;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (mouse_clr) begin
      dx_d = '0;
      dy_d = '0;
      wh_d = '0;
    end

    // Frame end: first cycle rpt_rdy reads low after being high.
    if (rdy_q && !rpt_rdy) begin
      case (typ)
        TYP_NONE: ;
        TYP_MOUSE: begin
          if (cnt_q >= CNT_W'(3)) begin
            btn_d    = byte_c[0];
            dx_d     = sat_add(mouse_clr ? '0 : dx_q, byte_c[1]);
            dy_d     = sat_add(mouse_clr ? '0 : dy_q, byte_c[2]);
            wh_d     = sat_add(mouse_clr ? '0 : wh_q, byte_c[3]);
            report_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        TYP_GAME: begin
          if (cnt_q >= CNT_W'(1)) begin
            game_d   = byte_c;
            report_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        TYP_KBD: begin
          if (cnt_q < CNT_W'(3) || state_q != ST_IDLE) begin
            ferr_d = 1'b1;
          end else begin
            new_mod_d = byte_c[0];
            for (int k = 0; k < int'(NUM_KEYS); k++) new_keys_d[k] = byte_c[k+2];
            state_d = ST_SNAP;
            idx_d   = '0;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        // Device gone with keys still held: diff against an empty report.
        if (typ != TYP_KBD && (old_mod_q != 8'h00 || old_keys_q != '0)) begin
          new_mod_d  = '0;
          new_keys_d = '0;
          state_d    = ST_SNAP;
          idx_d      = '0;
        end
      end
      ST_SNAP: begin
        for (int j = 0; j < int'(NUM_KEYS); j++)
          if (new_keys_q[j] == HID_ERR_ROLLOVER) hit_c = 1'b1;
        state_d = hit_c ? ST_IDLE : ST_BRK;
        idx_d   = '0;
      end
      ST_BRK: begin
        for (int j = 0; j < int'(NUM_KEYS); j++)
          if (new_keys_q[j] == old_keys_q[slot_c]) hit_c = 1'b1;
        if (old_keys_q[slot_c] != 8'h00 && !hit_c) begin
          push_c     = 1'b1;
          push_evt_c = '{press: 1'b0, usage: old_keys_q[slot_c]};
        end
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          idx_d   = '0;
          state_d = ST_MK;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_MK: begin
        for (int j = 0; j < int'(NUM_KEYS); j++) begin
          if (old_keys_q[j] == new_keys_q[slot_c]) hit_c = 1'b1;
          if (SLOT_W'(j) < slot_c && new_keys_q[j] == new_keys_q[slot_c]) dup_c = 1'b1;
        end
        if (new_keys_q[slot_c] != 8'h00 && !hit_c && !dup_c) begin
          push_c     = 1'b1;
          push_evt_c = '{press: 1'b1, usage: new_keys_q[slot_c]};
        end
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          idx_d   = '0;
          state_d = ST_MOD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_MOD: begin
        if (old_mod_q[idx_q[2:0]] != new_mod_q[idx_q[2:0]]) begin
          push_c     = 1'b1;
          push_evt_c = '{press: new_mod_q[idx_q[2:0]],
                         usage: HID_MOD_BASE + {5'd0, idx_q[2:0]}};
        end
        if (idx_q == IDX_W'(7)) begin
          idx_d   = '0;
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        old_mod_d  = new_mod_q;
        old_keys_d = new_keys_q;
        mods_d     = new_mod_q;
        keys_d     = new_keys_q;
        report_d   = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The FSM never waits on the FIFO; pushes into a full FIFO are lost and flagged.
  assign drop_c    = push_c & evt_full_c & ~(evt_ready & ~evt_empty_c);
  assign evt_ovf_d = evt_ovf_q | drop_c;

  always_ff @(posedge usbclk) begin
    if (!usbrst_n) begin
      rdy_q      <= 1'b0;
      stb_q      <= 1'b0;
      cnt_q      <= '0;
      rbuf_q     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      new_mod_q  <= '0;
      new_keys_q <= '0;
      old_mod_q  <= '0;
      old_keys_q <= '0;
      keys_q     <= '0;
      mods_q     <= '0;
      report_q   <= 1'b0;
      ferr_q     <= 1'b0;
      evt_ovf_q  <= 1'b0;
      btn_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      wh_q       <= '0;
      game_q     <= '0;
    end else begin
      rdy_q      <= rdy_d;
      stb_q      <= stb_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      new_mod_q  <= new_mod_d;
      new_keys_q <= new_keys_d;
      old_mod_q  <= old_mod_d;
      old_keys_q <= old_keys_d;
      keys_q     <= keys_d;
      mods_q     <= mods_d;
      report_q   <= report_d;
      ferr_q     <= ferr_d;
      evt_ovf_q  <= evt_ovf_d;
      btn_q      <= btn_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      wh_q       <= wh_d;
      game_q     <= game_d;
    end
  end

  hid_evt_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (EVT_W)
  ) u_evt_fifo (
    .clk_i   (usbclk),
    .rst_ni  (usbrst_n),
    .push_i  (push_c),
    .data_i  (push_evt_c),
    .pop_i   (evt_ready),
    .data_o  (evt_data),
    .empty_o (evt_empty_c),
    .full_o  (evt_full_c)
  );

  assign report        = report_q;
  assign frame_err     = ferr_q;
  assign key_modifiers = mods_q;
  assign keys          = keys_q;
  assign evt_valid     = ~evt_empty_c;
  assign evt_ovf       = evt_ovf_q;
  assign mouse_btn     = btn_q;
  assign mouse_dx      = dx_q;
  assign mouse_dy      = dy_q;
  assign mouse_wh      = wh_q;
  assign game_raw      = game_q;

endmodule

// File: tb/tb_usb_hid_report_decoder.sv
// Directed bench for usb_hid_report_decoder at default parameters.
module tb_usb_hid_report_decoder;
  import usb_hid_pkg::*;

  logic        usbclk = 1'b0;
  logic        usbrst_n;
  logic [1:0]  typ;
  logic        rpt_rdy, rpt_stb, evt_ready, mouse_clr;
  logic [7:0]  rpt_dat;
  logic        report, frame_err, evt_valid, evt_ovf;
  logic [7:0]  key_modifiers, mouse_btn;
  logic [47:0] keys;
  logic [8:0]  evt_data;
  logic [11:0] mouse_dx, mouse_dy, mouse_wh;
  logic [63:0] game_raw;

  int          n_checks = 0;
  int          n_err    = 0;
  int          rpt_cnt  = 0;
  int          ferr_cnt = 0;
  logic [8:0]  evq [$];

  usb_hid_report_decoder dut (
    .usbclk        (usbclk),
    .usbrst_n      (usbrst_n),
    .typ           (typ),
    .rpt_rdy       (rpt_rdy),
    .rpt_stb       (rpt_stb),
    .rpt_dat       (rpt_dat),
    .report        (report),
    .frame_err     (frame_err),
    .key_modifiers (key_modifiers),
    .keys          (keys),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_data      (evt_data),
    .evt_ovf       (evt_ovf),
    .mouse_btn     (mouse_btn),
    .mouse_dx      (mouse_dx),
    .mouse_dy      (mouse_dy),
    .mouse_wh      (mouse_wh),
    .mouse_clr     (mouse_clr),
    .game_raw      (game_raw)
  );

  always #5 usbclk = ~usbclk;

  // Consumer side: record popped events and count pulses away from the active edge.
  always @(negedge usbclk) begin
    if (usbrst_n === 1'b1) begin
      if (evt_valid && evt_ready) evq.push_back(evt_data);
      if (report) rpt_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic tick();
    @(posedge usbclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ev_at(input int i);
    if (i < evq.size()) return {3'b000, evq[i]};
    return 12'hFFF;
  endfunction

  // Byte i of d goes out as the i-th strobe; frame end follows the last byte.
  task automatic send_frame(input logic [71:0] d, input int n);
    rpt_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      rpt_dat = d[8*i +: 8];
      rpt_stb = 1'b1;
      tick();
      rpt_stb = 1'b0;
      tick();
    end
    rpt_rdy = 1'b0;
    tick();
  endtask

  task automatic wait_report(input int maxc, output int lat);
    lat = 0;
    while (report !== 1'b1 && lat < maxc) begin
      tick();
      lat++;
    end
    chk("report_seen", {63'd0, report}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r0, f0;
    logic [8:0] exp8 [8];
    exp8 = '{9'h005, 9'h006, 9'h10A, 9'h10B, 9'h10C, 9'h10D, 9'h10E, 9'h10F};

    usbrst_n = 1'b0; typ = TYP_NONE; rpt_rdy = 1'b0; rpt_stb = 1'b0; rpt_dat = 8'h00;
    evt_ready = 1'b1; mouse_clr = 1'b0;
    repeat (3) tick();
    chk("rst_report", {63'd0, report}, 64'd0);
    chk("rst_keys", {16'd0, keys}, 64'd0);
    chk("rst_evt_valid", {63'd0, evt_valid}, 64'd0);
    chk("rst_ovf", {63'd0, evt_ovf}, 64'd0);
    chk("rst_dx", {52'd0, mouse_dx}, 64'd0);
    chk("rst_game", game_raw, 64'd0);
    usbrst_n = 1'b1;
    typ = TYP_KBD;
    tick();

    // Press 04, 05
    evq.delete();
    send_frame(72'h05040000, 8);
    wait_report(40, lat);
    chk("A_latency", 64'(lat), 64'd22);
    tick();
    chk("A_nevt", 64'(evq.size()), 64'd2);
    chk("A_ev0", {52'd0, ev_at(0)}, 64'h104);
    chk("A_ev1", {52'd0, ev_at(1)}, 64'h105);
    chk("A_keys", {16'd0, keys}, 64'h0504);

    // Release 04, press 06, left shift
    evq.delete();
    send_frame(72'h06050002, 8);
    wait_report(40, lat);
    tick();
    chk("B_nevt", 64'(evq.size()), 64'd3);
    chk("B_ev0", {52'd0, ev_at(0)}, 64'h004);
    chk("B_ev1", {52'd0, ev_at(1)}, 64'h106);
    chk("B_ev2", {52'd0, ev_at(2)}, 64'h1E1);
    chk("B_keys", {16'd0, keys}, 64'h0605);
    chk("B_mods", {56'd0, key_modifiers}, 64'h02);

    // ErrorRollOver frame is discarded silently
    evq.delete();
    r0 = rpt_cnt; f0 = ferr_cnt;
    send_frame(72'h010000, 8);
    repeat (30) tick();
    chk("RO_report", 64'(rpt_cnt - r0), 64'd0);
    chk("RO_ferr", 64'(ferr_cnt - f0), 64'd0);
    chk("RO_nevt", 64'(evq.size()), 64'd0);
    chk("RO_keys", {16'd0, keys}, 64'h0605);

    // Ten events with consumer stalled: eight kept, overflow flagged
    evt_ready = 1'b0;
    evq.delete();
    send_frame(72'h0F0E0D0C0B0A0001, 8);
    wait_report(40, lat);
    tick();
    chk("OV_valid", {63'd0, evt_valid}, 64'd1);
    chk("OV_flag", {63'd0, evt_ovf}, 64'd1);
    chk("OV_keys", {16'd0, keys}, 64'h0F0E0D0C0B0A);
    evt_ready = 1'b1;
    repeat (12) tick();
    chk("OV_nevt", 64'(evq.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("OV_ev%0d", i), {52'd0, ev_at(i)}, {55'd0, exp8[i]});
    chk("OV_empty", {63'd0, evt_valid}, 64'd0);

    // Second frame lands while the first diff is running
    evq.delete();
    r0 = rpt_cnt;
    send_frame(72'h040000, 3);
    send_frame(72'h090000, 3);
    chk("DF_ferr", {63'd0, frame_err}, 64'd1);
    wait_report(40, lat);
    repeat (5) tick();
    chk("DF_nreport", 64'(rpt_cnt - r0), 64'd1);
    chk("DF_keys", {16'd0, keys}, 64'h04);
    chk("DF_mods", {56'd0, key_modifiers}, 64'h00);
    chk("DF_nevt", 64'(evq.size()), 64'd8);
    chk("DF_ev6", {52'd0, ev_at(6)}, 64'h104);
    chk("DF_ev7", {52'd0, ev_at(7)}, 64'h0E0);

    // Hold 04, 07 then disconnect
    send_frame(72'h07040000, 4);
    wait_report(40, lat);
    tick();
    chk("D_keys", {16'd0, keys}, 64'h0704);
    evq.delete();
    typ = TYP_NONE;
    wait_report(40, lat);
    tick();
    chk("DC_nevt", 64'(evq.size()), 64'd2);
    chk("DC_ev0", {52'd0, ev_at(0)}, 64'h004);
    chk("DC_ev1", {52'd0, ev_at(1)}, 64'h007);
    chk("DC_keys", {16'd0, keys}, 64'd0);
    r0 = rpt_cnt;
    repeat (30) tick();
    chk("DC_quiet", 64'(rpt_cnt - r0), 64'd0);

    // typ=0 frames are ignored
    send_frame(72'h030201, 3);
    chk("NONE_report", {63'd0, report}, 64'd0);
    chk("NONE_ferr", {63'd0, frame_err}, 64'd0);

    // Mouse
    typ = TYP_MOUSE;
    tick();
    send_frame(72'h0501, 2);
    chk("MS_short_ferr", {63'd0, frame_err}, 64'd1);
    chk("MS_short_report", {63'd0, report}, 64'd0);
    chk("MS_short_dx", {52'd0, mouse_dx}, 64'd0);
    for (int i = 0; i < 25; i++) begin
      send_frame(72'h00006400, 4);
      if (i == 0) begin
        chk("MS_first_report", {63'd0, report}, 64'd1);
        chk("MS_first_dx", {52'd0, mouse_dx}, 64'h064);
      end
    end
    chk("MS_sat_dx", {52'd0, mouse_dx}, 64'h7FF);
    chk("MS_sat_dy", {52'd0, mouse_dy}, 64'h000);
    mouse_clr = 1'b1;
    send_frame(72'h8102FB03, 4);
    mouse_clr = 1'b0;
    chk("MS_clr_report", {63'd0, report}, 64'd1);
    chk("MS_clr_dx", {52'd0, mouse_dx}, 64'hFFB);
    chk("MS_clr_dy", {52'd0, mouse_dy}, 64'h002);
    chk("MS_clr_wh", {52'd0, mouse_wh}, 64'hF81);
    chk("MS_btn", {56'd0, mouse_btn}, 64'h03);

    // Gamepad: ninth byte dropped, short frame zero-filled
    typ = TYP_GAME;
    tick();
    send_frame(72'h998877665544332211, 9);
    chk("GP_report", {63'd0, report}, 64'd1);
    chk("GP_raw_full", game_raw, 64'h8877665544332211);
    send_frame(72'hBBAA, 2);
    chk("GP_raw_short", game_raw, 64'hBBAA);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
